// File: rtl/reaction_timer.sv
// Reaction timer: measures ms from lights-out to a debounced key press,
// flags false starts and tracks the best (smallest) valid reaction.
module reaction_timer #(
  parameter int DEBOUNCE_MS = 5,
  parameter int MAX_MS      = 9999,
  parameter int CW          = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          tick_ms,
  input  logic          arm,
  input  logic          time_out,
  input  logic          react_n,
  output logic [CW-1:0] reaction_ms,
  output logic          result_valid,
  output logic          false_start,
  output logic [CW-1:0] best_ms,
  output logic          busy
);

  localparam int DBW = $clog2(DEBOUNCE_MS + 1);

  typedef enum logic [2:0] {IDLE, WAIT_GO, TIMING, DONE, FAULT} state_t;

  state_t          state, state_nxt;
  logic            sync_p0, sync_p1;
  logic            db_lvl, db_lvl_d;
  logic [DBW-1:0]  db_cnt;
  logic            time_out_d;
  logic            press, go;
  logic [CW-1:0]   count;
  logic            clr_round, clr_cnt, do_press, do_tmo, do_fault, do_best;

  // Removes the debounce latency from the raw count, floored at zero.
  function automatic logic [CW-1:0] sub_latency(input logic [CW-1:0] v);
    if (v >= CW'(DEBOUNCE_MS)) return v - CW'(DEBOUNCE_MS);
    else                       return '0;
  endfunction

  // Input conditioning: 2-flop synchronizer, then tick-sampled debounce
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0    <= 1'b1;
      sync_p1    <= 1'b1;
      db_lvl     <= 1'b1;
      db_lvl_d   <= 1'b1;
      db_cnt     <= '0;
      time_out_d <= 1'b0;
    end else begin
      sync_p0    <= react_n;
      sync_p1    <= sync_p0;
      db_lvl_d   <= db_lvl;
      time_out_d <= time_out;
      if (tick_ms) begin
        if (sync_p1 == db_lvl) begin
          db_cnt <= '0;
        end else if (db_cnt == DBW'(DEBOUNCE_MS - 1)) begin
          db_lvl <= sync_p1;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end
    end
  end

  assign press = db_lvl_d & ~db_lvl;
  assign go    = time_out & ~time_out_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr_round = 1'b0;
    clr_cnt   = 1'b0;
    do_press  = 1'b0;
    do_tmo    = 1'b0;
    do_fault  = 1'b0;
    do_best   = 1'b0;
    case (state)
      IDLE: if (arm) begin
        state_nxt = WAIT_GO;
        clr_round = 1'b1;
        clr_cnt   = 1'b1;
      end
      WAIT_GO: begin
        // A press wins over a simultaneous lights-out edge.
        if (press) begin
          state_nxt = FAULT;
          do_fault  = 1'b1;
        end else if (go) begin
          state_nxt = TIMING;
          clr_cnt   = 1'b1;
        end
      end
      TIMING: begin
        if (press) begin
          state_nxt = DONE;
          do_press  = 1'b1;
        end else if (count == CW'(MAX_MS)) begin
          state_nxt = DONE;
          do_tmo    = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        do_best   = 1'b1;
      end
      FAULT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Count, result and best-time registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count        <= '0;
      reaction_ms  <= '0;
      best_ms      <= '1;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      if (clr_cnt)
        count <= '0;
      else if (state == TIMING && tick_ms && count != CW'(MAX_MS))
        count <= count + 1'b1;

      if (clr_round) begin
        result_valid <= 1'b0;
        false_start  <= 1'b0;
      end
      if (do_fault) begin
        false_start  <= 1'b1;
        result_valid <= 1'b0;
      end
      if (do_press) begin
        reaction_ms  <= sub_latency(count);
        result_valid <= 1'b1;
      end
      if (do_tmo) begin
        reaction_ms  <= CW'(MAX_MS);
        result_valid <= 1'b1;
      end
      // A genuine press can never report MAX_MS, so that value marks a timeout.
      if (do_best && reaction_ms < best_ms && reaction_ms != CW'(MAX_MS))
        best_ms <= reaction_ms;

      busy <= (state_nxt == WAIT_GO) || (state_nxt == TIMING);
    end
  end

endmodule

// File: tb/tb_reaction_timer.sv
// Randomized scoreboard bench for reaction_timer; the reference model works
// in whole milliseconds relative to the lights-out moment.
module tb_reaction_timer;

  localparam int DB   = 5;
  localparam int MAXV = 9999;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          tick_ms = 1'b0;
  logic          arm = 1'b0;
  logic          time_out = 1'b0;
  logic          react_n = 1'b1;
  logic [CW-1:0] reaction_ms, best_ms;
  logic          result_valid, false_start, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic rv;
    logic fs;
    int   rms;
    int   best;
  } exp_t;

  exp_t sb[$];
  int   m_best;
  int   m_last;

  reaction_timer #(.DEBOUNCE_MS(DB), .MAX_MS(MAXV), .CW(CW)) dut (
    .clk(clk), .reset_n(reset_n), .tick_ms(tick_ms), .arm(arm),
    .time_out(time_out), .react_n(react_n), .reaction_ms(reaction_ms),
    .result_valid(result_valid), .false_start(false_start),
    .best_ms(best_ms), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // One millisecond = four clocks; tick_ms is high during the first.
  task automatic ms_step(input bit a, input bit to_val, input bit to_late, input bit rn);
    @(negedge clk); tick_ms = 1'b1; arm = a; time_out = to_val; react_n = rn;
    @(negedge clk); tick_ms = 1'b0; arm = 1'b0; if (to_late) time_out = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  // rel = ms from lights-out to the final key-down (negative = before).
  // The key is only recognised DB ms after it goes down, so a press counts as
  // a false start when it is recognised before lights-out (or in the same clk).
  task automatic predict(input int rel, input bit has_press, input bit late);
    exp_t e;
    if (!has_press) begin
      e.rv = 1'b1; e.fs = 1'b0; e.rms = MAXV;
    end else if (late ? (rel <= -DB) : (rel <= -DB - 1)) begin
      e.rv = 1'b0; e.fs = 1'b1; e.rms = m_last;
    end else begin
      e.rv = 1'b1; e.fs = 1'b0; e.rms = (rel < 0) ? 0 : rel;
    end
    if (e.rv && e.rms != MAXV && e.rms < m_best) m_best = e.rms;
    m_last = e.rms;
    e.best = m_best;
    sb.push_back(e);
  endtask

  // g = ms from arm to lights-out; bounce = ms of alternating key chatter before key-down.
  task automatic run_round(input int g, input int rel, input bit has_press,
                           input int bounce, input bit late);
    int k;
    int lim;
    bit ok;
    bit rn;
    bit tv;
    k  = g + rel;
    ok = 1'b0;
    predict(rel, has_press, late);
    lim = has_press ? (((g > k) ? g : k) + 8) : g + 2;
    for (int t = 0; t < g + MAXV + 40; t++) begin
      rn = 1'b1;
      if (has_press) begin
        if (t >= k) rn = 1'b0;
        else if (bounce > 0 && t >= k - bounce) rn = ((k - t) % 2 == 1);
      end
      tv = (t > g) || (t == g && !late);
      ms_step(t == 0, tv, (t == g) && late, rn);
      if (t >= lim && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("round_completes", ok, 1);
    for (int i = 0; i < 8; i++) ms_step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: a round has ended when busy falls outside reset.
  initial begin
    bit   bq;
    exp_t e;
    bq = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && bq && !busy) begin
        @(negedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=1 required=0");
        end else begin
          e = sb.pop_front();
          chk("result_valid", result_valid, e.rv);
          chk("false_start", false_start, e.fs);
          chk("reaction_ms", reaction_ms, e.rms);
          chk("best_ms", best_ms, e.best);
        end
      end
      bq = busy;
    end
  end

  initial begin
    int g;
    int rel;
    m_best = 'hFFFF;
    m_last = 0;

    repeat (3) @(negedge clk);
    chk("rst_reaction", reaction_ms, 0);
    chk("rst_best", best_ms, 'hFFFF);
    chk("rst_valid", result_valid, 0);
    chk("rst_fstart", false_start, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) ms_step(1'b0, 1'b0, 1'b0, 1'b1);

    run_round(60, 77, 1'b1, 0, 1'b0);

    // Asynchronous reset in the middle of TIMING
    for (int t = 0; t < 40; t++) ms_step(t == 0, t >= 5, 1'b0, 1'b1);
    chk("timing_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_reaction", reaction_ms, 0);
    chk("midrst_best", best_ms, 'hFFFF);
    chk("midrst_valid", result_valid, 0);
    chk("midrst_fstart", false_start, 0);
    m_best = 'hFFFF;
    m_last = 0;
    @(negedge clk); time_out = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 8; i++) ms_step(1'b0, 1'b0, 1'b0, 1'b1);

    run_round(50, 250, 1'b1, 0, 1'b0);
    run_round(55, 400, 1'b1, 0, 1'b0);
    run_round(45, 180, 1'b1, 0, 1'b0);
    run_round(60, -20, 1'b1, 0, 1'b0);
    run_round(60, -DB, 1'b1, 0, 1'b1);
    run_round(40, 120, 1'b1, 4, 1'b0);

    for (int r = 0; r < 6; r++) begin
      g = int'($urandom_range(80, 45));
      if ($urandom_range(3, 0) == 0) rel = -int'($urandom_range(40, 6));
      else                           rel = int'($urandom_range(150, 0));
      run_round(g, rel, 1'b1, 0, 1'b0);
    end

    run_round(50, -3, 1'b1, 0, 1'b0);
    run_round(30, 0, 1'b0, 0, 1'b0);

    // A press while idle after a timeout changes nothing
    for (int i = 0; i < 10; i++) ms_step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_press_busy", busy, 0);
    for (int i = 0; i < 8; i++) ms_step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("idle_press_reaction", reaction_ms, MAXV);
    chk("idle_press_valid", result_valid, 1);
    chk("idle_press_fstart", false_start, 0);
    chk("idle_press_best", best_ms, m_best);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Measures player reaction time in milliseconds: from the moment the DELAY stage signals lights-out (time_out) until the player presses the react key.
- Sits downstream of the DELAY stage and feeds the 16-bit binary-to-BCD converter and the seven-segment display path.
- Detects false starts (a press before lights-out) and keeps a best-time record.
- Runs on the 50 MHz system clock and uses the 1 ms tick as a clock enable.

Parameters:
- DEBOUNCE_MS, 5, number of consecutive tick_ms samples of stable key level needed to accept a level change
- MAX_MS, 9999, saturation/timeout value of the reaction count in ms
- CW, 16, width of the count and result registers

Ports:
- clk  input  1  50 MHz system clock
- reset_n  input  1  asynchronous active-low reset
- tick_ms  input  1  one-clk-wide pulse every 1 ms, used as the count/debounce enable
- arm  input  1  one-clk pulse from the sequencing FSM marking the start of a new round
- time_out  input  1  level from DELAY, high once the random delay has expired (lights-out)
- react_n  input  1  raw, asynchronous, active-low react key
- reaction_ms  output  CW  last reaction result in ms
- result_valid  output  1  high while reaction_ms holds a result from a completed round
- false_start  output  1  high when the last round ended in a false start
- best_ms  output  CW  smallest valid reaction so far
- busy  output  1  high in WAIT_GO or TIMING

Behaviour:
- Reset (asynchronous, reset_n low):
  - state=IDLE; counter=0; reaction_ms=0; best_ms=all ones; result_valid=0; false_start=0.
  - Synchronizer flops and debounced level reset to 1 (released). Debounce counter reset to 0.
- Reset asserted mid-round aborts the round immediately; no result and no best update.
- Input conditioning:
  - react_n passes through a 2-flop synchronizer.
  - Debounced level changes only after the synchronized level differs from it on DEBOUNCE_MS consecutive tick_ms pulses.
  - A sample matching the current debounced level clears the debounce counter.
  - press = one-clk pulse on the 1->0 transition of the debounced level.
- Lights-out edge: go = time_out high this clk and low the previous clk (registered edge detect).
- States:
  - IDLE: arm -> WAIT_GO; clear result_valid and false_start; counter=0.
  - WAIT_GO:
    - press -> FAULT; false_start=1; result_valid=0.
    - else go -> TIMING; counter=0.
    - press and go in the same clk -> FAULT (press has priority).
  - TIMING:
    - Counter increments on each tick_ms, saturating at MAX_MS.
    - press -> DONE. The value latched is the counter before any increment in that clk.
    - reaction_ms = latched - DEBOUNCE_MS, floored at 0 (compensates debounce latency).
    - Counter reaching MAX_MS -> DONE with reaction_ms=MAX_MS.
  - DONE:
    - One clk. result_valid=1.
    - If reaction_ms < best_ms, best_ms <= reaction_ms. Timeout results (MAX_MS) never update best_ms.
    - -> IDLE.
  - FAULT: one clk -> IDLE. reaction_ms is left unchanged.
- arm in any non-IDLE state is ignored.
- A press in IDLE, DONE or FAULT is ignored.
- Outputs reaction_ms, result_valid, false_start and best_ms hold their values until the next arm or reset.
- busy = (state==WAIT_GO or TIMING), registered.
- All state, counter and output updates are synchronous to clk. Only reset is asynchronous.

Test Plan:
- Reset then idle: hold reset_n low mid-TIMING -> state IDLE, reaction_ms=0, best_ms=16'hFFFF, result_valid=0, busy=0 immediately, without waiting for a clk edge.
- Normal round: arm, then time_out rises, then react_n held low from 250 tick_ms later -> result_valid=1, reaction_ms=250, best_ms=250, busy falls.
- Second, slower round (reaction_ms=400) -> best_ms stays 250. Third round (reaction_ms=180) -> best_ms=180.
- False start: arm, react_n low before time_out -> false_start=1, result_valid=0, best_ms unchanged. Same result when the press and the time_out edge land in the same clk.
- Bounce: react_n toggles every 1 ms for 4 ms, then is held low -> exactly one press, and the reported value excludes the bounce window.
- Timeout: arm, time_out rises, no press for 10000 ms -> reaction_ms=9999, result_valid=1, best_ms unchanged. A press afterwards is ignored.
